// File: rtl/ssp_frame_engine.sv
// SSP link engine: registered pass-through of the HF mode SSP signals, or a self-clocked
// engine that transmits a test/echo word to the ARM and captures full words from it.
module ssp_frame_engine #(
    parameter int          FRAME_BITS = 32,
    parameter int          DIV_LOG2   = 3,
    parameter logic [31:0] PATTERN    = 32'hDEADBEEF
) (
    input  logic                  ck_1356meg,
    input  logic                  reset,
    input  logic [1:0]            mode,
    input  logic [FRAME_BITS-1:0] pattern_in,
    input  logic                  pattern_load,
    input  logic                  hi_ssp_clk,
    input  logic                  hi_ssp_frame,
    input  logic                  hi_ssp_din,
    input  logic                  ssp_dout,
    output logic                  ssp_clk,
    output logic                  ssp_frame,
    output logic                  ssp_din,
    output logic [FRAME_BITS-1:0] rx_word,
    output logic                  rx_valid,
    output logic [7:0]            frame_count
);

    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_RX   = 2'b01,
        MODE_TX   = 2'b10,
        MODE_LOOP = 2'b11
    } mode_e;

    localparam int PS_W = (DIV_LOG2 > 0) ? DIV_LOG2 : 1;
    localparam int BI_W = (FRAME_BITS > 2) ? $clog2(FRAME_BITS) : 1;
    localparam logic [PS_W-1:0] PS_MAX   = PS_W'((1 << DIV_LOG2) - 1);
    localparam logic [BI_W-1:0] BIT_LAST = BI_W'(FRAME_BITS - 1);

    mode_e                  mode_p1;
    logic [PS_W-1:0]        prescaler;
    logic [BI_W-1:0]        bit_idx;
    logic [FRAME_BITS-1:0]  tx_shift;
    logic [FRAME_BITS-1:0]  rx_shift;
    logic [FRAME_BITS-1:0]  echo_word;
    logic [FRAME_BITS-1:0]  pattern;

    logic                   tick;
    logic                   mode_chg;
    logic [FRAME_BITS-1:0]  tx_src;
    logic [FRAME_BITS-1:0]  tx_cur;
    logic [FRAME_BITS-1:0]  rx_next;

    assign tick     = (prescaler == PS_MAX);
    assign mode_chg = (mode != mode_p1);
    assign rx_next  = {rx_shift[FRAME_BITS-2:0], ssp_dout};

    // A same-cycle pattern_load wins so a load coincident with frame start goes out at once.
    always_comb begin
        tx_src = '0;
        case (mode_e'(mode))
            MODE_TX:   tx_src = pattern_load ? pattern_in : pattern;
            MODE_LOOP: tx_src = echo_word;
            default:   tx_src = '0;
        endcase
        tx_cur = (bit_idx == '0) ? tx_src : tx_shift;
    end

    always_ff @(posedge ck_1356meg) begin
        if (reset) begin
            mode_p1     <= mode_e'(mode);
            prescaler   <= '0;
            bit_idx     <= '0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            echo_word   <= '0;
            pattern     <= PATTERN[FRAME_BITS-1:0];
            ssp_clk     <= 1'b0;
            ssp_frame   <= 1'b0;
            ssp_din     <= 1'b0;
            rx_word     <= '0;
            rx_valid    <= 1'b0;
            frame_count <= '0;
        end else begin
            mode_p1  <= mode_e'(mode);
            rx_valid <= 1'b0;
            if (pattern_load)
                pattern <= pattern_in;

            if (mode_chg || mode_e'(mode) == MODE_PASS) begin
                prescaler <= '0;
                bit_idx   <= '0;
                tx_shift  <= '0;
                rx_shift  <= '0;
                // The switching cycle itself drives zeros; pass-through starts the cycle after.
                ssp_clk   <= mode_chg ? 1'b0 : hi_ssp_clk;
                ssp_frame <= mode_chg ? 1'b0 : hi_ssp_frame;
                ssp_din   <= mode_chg ? 1'b0 : hi_ssp_din;
            end else begin
                prescaler <= tick ? '0 : prescaler + 1'b1;
                if (tick) begin
                    ssp_clk <= ~ssp_clk;
                    if (!ssp_clk) begin
                        ssp_frame <= (bit_idx == '0);
                        if (bit_idx == '0)
                            tx_shift <= tx_src;
                        ssp_din <= tx_cur[FRAME_BITS-1];
                    end else begin
                        rx_shift <= rx_next;
                        if (bit_idx == BIT_LAST) begin
                            rx_word     <= rx_next;
                            rx_valid    <= 1'b1;
                            echo_word   <= rx_next;
                            frame_count <= frame_count + 8'd1;
                            bit_idx     <= '0;
                        end else begin
                            bit_idx  <= bit_idx + 1'b1;
                            tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ssp_frame_engine.sv
// Directed bench for ssp_frame_engine with FRAME_BITS=8, DIV_LOG2=0, PATTERN=8'hA5.
module tb_ssp_frame_engine;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] mode = 2'b10;
    logic [7:0] pattern_in = 8'h00;
    logic       pattern_load = 1'b0;
    logic       hi_ssp_clk = 1'b0;
    logic       hi_ssp_frame = 1'b0;
    logic       hi_ssp_din = 1'b0;
    logic       ssp_dout = 1'b0;
    logic       ssp_clk;
    logic       ssp_frame;
    logic       ssp_din;
    logic [7:0] rx_word;
    logic       rx_valid;
    logic [7:0] frame_count;

    int errors = 0;
    int checks = 0;

    ssp_frame_engine #(.FRAME_BITS(8), .DIV_LOG2(0), .PATTERN(32'h000000A5)) dut (
        .ck_1356meg  (clk),
        .reset       (reset),
        .mode        (mode),
        .pattern_in  (pattern_in),
        .pattern_load(pattern_load),
        .hi_ssp_clk  (hi_ssp_clk),
        .hi_ssp_frame(hi_ssp_frame),
        .hi_ssp_din  (hi_ssp_din),
        .ssp_dout    (ssp_dout),
        .ssp_clk     (ssp_clk),
        .ssp_frame   (ssp_frame),
        .ssp_din     (ssp_din),
        .rx_word     (rx_word),
        .rx_valid    (rx_valid),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    localparam int ST_CONT = 0;
    localparam int ST_RST  = 1;
    localparam int ST_MODE = 2;

    typedef struct {
        int         start;
        logic [1:0] md;
        logic [7:0] arm;
        logic [7:0] exp_din;
        logic [7:0] exp_fc;
        int         load_at;
        logic [7:0] load_val;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] m);
        reset = 1'b1;
        mode  = m;
        step();
        step();
        chk("reset_outs", {29'd0, ssp_clk, ssp_frame, ssp_din}, 32'd0);
        chk("reset_rx_word", {24'd0, rx_word}, 32'd0);
        chk("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("reset_frame_count", {24'd0, frame_count}, 32'd0);
        reset = 1'b0;
    endtask

    task automatic do_mode(input logic [1:0] m);
        mode = m;
        step();
        chk("mode_chg_zero", {29'd0, ssp_clk, ssp_frame, ssp_din}, 32'd0);
        chk("mode_chg_no_vld", {31'd0, rx_valid}, 32'd0);
    endtask

    // One full 8-bit frame at one tick per cycle: odd cycles are rising ticks, even are falling.
    task automatic run_frame(input logic [7:0] arm, input logic [7:0] exp_din,
                             input logic [7:0] exp_fc, input int load_at, input logic [7:0] load_val);
        logic [7:0] din_w;
        logic [7:0] frm_w;
        int clk_err;
        int extra_vld;
        int k;
        din_w = '0; frm_w = '0; clk_err = 0; extra_vld = 0;
        if (load_at == 0) begin
            pattern_in = load_val;
            pattern_load = 1'b1;
        end
        for (int c = 1; c <= 16; c++) begin
            step();
            pattern_load = 1'b0;
            if (ssp_clk !== c[0]) clk_err++;
            if (c[0]) begin
                k = (c - 1) / 2;
                din_w[7-k] = ssp_din;
                frm_w[7-k] = ssp_frame;
                ssp_dout = arm[7-k];
            end
            if (c < 16 && rx_valid) extra_vld++;
            if (c == load_at) begin
                pattern_in = load_val;
                pattern_load = 1'b1;
            end
        end
        chk("ssp_clk_toggle", clk_err, 0);
        chk("ssp_din_word", {24'd0, din_w}, {24'd0, exp_din});
        chk("ssp_frame_bits", {24'd0, frm_w}, 32'h80);
        chk("rx_valid_end", {31'd0, rx_valid}, 32'd1);
        chk("rx_valid_extra", extra_vld, 0);
        chk("rx_word", {24'd0, rx_word}, {24'd0, arm});
        chk("frame_count", {24'd0, frame_count}, {24'd0, exp_fc});
    endtask

    initial begin
        int vld_seen;
        vecs[0]  = '{ST_RST,  2'b10, 8'h00, 8'hA5, 8'd1, -1, 8'h00};
        vecs[1]  = '{ST_CONT, 2'b10, 8'h11, 8'hA5, 8'd2, -1, 8'h00};
        vecs[2]  = '{ST_CONT, 2'b10, 8'h00, 8'hA5, 8'd3, -1, 8'h00};
        vecs[3]  = '{ST_MODE, 2'b01, 8'h3C, 8'h00, 8'd4, -1, 8'h00};
        vecs[4]  = '{ST_MODE, 2'b11, 8'hC3, 8'h3C, 8'd5, -1, 8'h00};
        vecs[5]  = '{ST_CONT, 2'b11, 8'h5A, 8'hC3, 8'd6, -1, 8'h00};
        vecs[6]  = '{ST_RST,  2'b11, 8'h5A, 8'h00, 8'd1, -1, 8'h00};
        vecs[7]  = '{ST_CONT, 2'b11, 8'h00, 8'h5A, 8'd2, -1, 8'h00};
        vecs[8]  = '{ST_CONT, 2'b11, 8'h7E, 8'h00, 8'd3, -1, 8'h00};
        vecs[9]  = '{ST_MODE, 2'b10, 8'hB1, 8'hA5, 8'd4,  6, 8'hFF};
        vecs[10] = '{ST_CONT, 2'b10, 8'h0F, 8'hFF, 8'd5, -1, 8'h00};
        vecs[11] = '{ST_CONT, 2'b10, 8'hE2, 8'h3C, 8'd6,  0, 8'h3C};
        vecs[12] = '{ST_CONT, 2'b10, 8'h00, 8'h3C, 8'd7, -1, 8'h00};

        step();
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].start == ST_RST) do_reset(vecs[i].md);
            else if (vecs[i].start == ST_MODE) do_mode(vecs[i].md);
            run_frame(vecs[i].arm, vecs[i].exp_din, vecs[i].exp_fc, vecs[i].load_at, vecs[i].load_val);
        end

        // Mode 10 -> 00 mid-frame: one zero cycle, then hi_ssp_* with one cycle of lag.
        vld_seen = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (rx_valid) vld_seen++;
        end
        mode = 2'b00;
        hi_ssp_clk = 1'b1; hi_ssp_frame = 1'b1; hi_ssp_din = 1'b1;
        step();
        chk("pass_switch_zero", {29'd0, ssp_clk, ssp_frame, ssp_din}, 32'd0);
        step();
        chk("pass_track_111", {29'd0, ssp_clk, ssp_frame, ssp_din}, 32'd7);
        hi_ssp_clk = 1'b0; hi_ssp_frame = 1'b1; hi_ssp_din = 1'b0;
        chk("pass_lag_hold", {29'd0, ssp_clk, ssp_frame, ssp_din}, 32'd7);
        step();
        chk("pass_track_010", {29'd0, ssp_clk, ssp_frame, ssp_din}, 32'd2);
        pattern_in = 8'h81;
        pattern_load = 1'b1;
        step();
        pattern_load = 1'b0;
        if (rx_valid) vld_seen++;
        for (int c = 0; c < 20; c++) begin
            step();
            if (rx_valid) vld_seen++;
        end
        chk("pass_no_rx_valid", vld_seen, 0);
        chk("pass_frame_count", {24'd0, frame_count}, 32'd7);

        // Pattern loaded during pass-through, then a reset mid-frame restores PATTERN.
        do_mode(2'b10);
        run_frame(8'h66, 8'h81, 8'd8, -1, 8'h00);
        vld_seen = 0;
        for (int c = 0; c < 9; c++) begin
            step();
            if (rx_valid) vld_seen++;
        end
        do_reset(2'b10);
        if (rx_valid) vld_seen++;
        chk("reset_partial_no_vld", vld_seen, 0);
        run_frame(8'h24, 8'hA5, 8'd1, -1, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
